// File: rtl/sort_seq.sv
// Sequential odd-even transposition sorter: accepts an N-lane vector, runs N
// compare/exchange passes, and presents the sorted values with origin-lane tags.
module sort_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 4,
  localparam int unsigned IDXW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*WIDTH-1:0]  in_data,
  input  logic                mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*WIDTH-1:0]  out_data,
  output logic [N*IDXW-1:0]   out_idx
);

  localparam int unsigned CNTW = ($clog2(N) > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNTW-1:0]   pass_q;
  logic              mode_q;
  logic [WIDTH-1:0]  lane_q [N];
  logic [IDXW-1:0]   tag_q  [N];
  logic [WIDTH-1:0]  lane_nx [N];
  logic [IDXW-1:0]   tag_nx  [N];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SORT;
      end
      SORT: begin
        if (pass_q == CNTW'(N - 1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One transposition pass; pass parity picks even or odd pair starts.
  // Strict comparison keeps equal values in place, which makes the sort stable.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      lane_nx[i] = lane_q[i];
      tag_nx[i]  = tag_q[i];
    end
    for (int unsigned j = 0; j < N - 1; j++) begin
      if ((1'(j) == pass_q[0]) &&
          (mode_q ? (lane_q[j] > lane_q[j+1]) : (lane_q[j] < lane_q[j+1]))) begin
        lane_nx[j]   = lane_q[j+1];
        lane_nx[j+1] = lane_q[j];
        tag_nx[j]    = tag_q[j+1];
        tag_nx[j+1]  = tag_q[j];
      end
    end
  end

  // Lane, tag, mode and pass counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= '0;
      mode_q <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        lane_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            pass_q <= '0;
            mode_q <= mode;
            for (int unsigned i = 0; i < N; i++) begin
              lane_q[i] <= in_data[i*WIDTH +: WIDTH];
              tag_q[i]  <= IDXW'(i);
            end
          end
        end
        SORT: begin
          pass_q <= pass_q + CNTW'(1);
          for (int unsigned i = 0; i < N; i++) begin
            lane_q[i] <= lane_nx[i];
            tag_q[i]  <= tag_nx[i];
          end
        end
        default: ;
      endcase
    end
  end

  // Lane registers drive the outputs directly in every state
  for (genvar g = 0; g < N; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH] = lane_q[g];
    assign out_idx[g*IDXW +: IDXW]    = tag_q[g];
  end

endmodule

// File: doc/sort_seq.md
SORT_SEQ -- requirements
Module: sort_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bits per unsigned element (legal 1..32).
REQ-002 SHALL have parameter N, default 4, meaning element count (legal 2..16).
REQ-003 SHALL define local IDXW = max(1, clog2(N)), meaning width of one origin-index tag.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports listed below, clock and reset first.
REQ-005 SHALL provide port clk  input  1  rising-edge clock.
REQ-006 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL provide port in_valid  input  1  input vector offered.
REQ-008 SHALL provide port in_ready  output  1  block can accept a vector.
REQ-009 SHALL provide port in_data  input  N*WIDTH  unsorted vector; lane i = bits [i*WIDTH +: WIDTH].
REQ-010 SHALL provide port mode  input  1  sort order; 0 = descending, 1 = ascending.
REQ-011 SHALL provide port out_valid  output  1  sorted vector available.
REQ-012 SHALL provide port out_ready  input  1  consumer accepts the sorted vector.
REQ-013 SHALL provide port out_data  output  N*WIDTH  sorted vector, same lane packing as in_data.
REQ-014 SHALL provide port out_idx  output  N*IDXW  for each output lane, the input lane its value came from.

Function
REQ-015 SHALL implement FSM states IDLE, SORT, DONE.
REQ-016 SHALL assert in_ready only in IDLE; out_valid only in DONE (both registered-state decodes).
REQ-017 SHALL, in IDLE on a clk edge with in_valid=1, load in_data into N lane registers, load lane i's tag = i, latch mode, clear pass counter, go to SORT.
REQ-018 SHALL perform exactly N odd-even transposition passes in SORT, one per clock; pass p (0-based) compares lane pairs (j, j+1) with j even when p even, j odd when p odd.
REQ-019 SHALL swap a pair (data and tag together) only when strictly out of order: descending swaps if lane j < lane j+1; ascending swaps if lane j > lane j+1; equal values never swap (stable sort).
REQ-020 SHALL compare unsigned, full WIDTH bits.
REQ-021 SHALL go to DONE on the edge that completes pass N-1; out_valid rises exactly N clocks after the accepting edge.
REQ-022 SHALL hold out_data, out_idx and out_valid stable in DONE until out_ready=1 on a clk edge, then return to IDLE.
REQ-023 SHALL use the mode value latched at acceptance; changes to mode during SORT/DONE have no effect.
REQ-024 SHALL ignore in_valid and in_data while not in IDLE (no buffering, no overwrite).
REQ-025 SHALL drive out_data/out_idx from the lane registers in all states; values are only meaningful while out_valid=1.
REQ-026 SHALL accept a new vector no earlier than the clock after the out_ready handshake (throughput one vector per N+2 clocks minimum).
REQ-027 SHALL, for N odd, still run N passes, and the lane without a partner in a pass passes unchanged.

Reset
REQ-028 SHALL, on rst_n=0, immediately force state IDLE, pass counter 0, all lane data 0, all tags 0, latched mode 0.
REQ-029 SHALL therefore reset outputs to in_ready=1, out_valid=0, out_data=0, out_idx=0.
REQ-030 SHALL abort any SORT or DONE in progress on reset; the pending vector is discarded with no partial output.

Verification
REQ-031 SHALL cover: N=4, W=16, mode=0, in lanes {0x0003,0x0100,0x0001,0xFFFF} -> 4 clocks later out lanes {0xFFFF,0x0100,0x0003,0x0001}, out_idx {3,1,0,2}.
REQ-032 SHALL cover: same vector, mode=1 -> out lanes {0x0001,0x0003,0x0100,0xFFFF}, out_idx {2,0,1,3}.
REQ-033 SHALL cover: mode=0, lanes {5,5,9,5} -> out {9,5,5,5}, out_idx {2,0,1,3} (stability).
REQ-034 SHALL cover: out_ready held 0 for 10 clocks in DONE, in_valid toggling -> outputs stable, in_ready=0, no new load; then out_ready=1 -> IDLE next clock.
REQ-035 SHALL cover: rst_n pulsed low during pass 2 -> out_valid=0, in_ready=1, out_data=0 immediately; next vector sorts correctly.
REQ-036 SHALL cover: N=5, W=8, 1000 random vectors with random mode and out_ready back-pressure -> every output matches a stable reference sort.
